// File: rtl/pc_sequencer_pkg.sv
// ============================================================================
// Module   : pc_sequencer_pkg
// Brief    : Shared processor constants and the PC sequencer state encoding.
// Revision : 1.0
// ============================================================================
`default_nettype none

package pc_sequencer_pkg;

  localparam int unsigned PC_WIDTH        = 32;
  localparam logic [31:0] PC_RESET_VECTOR = 32'h0000_0000;

  typedef enum logic [0:0] {
    PCS_RUN     = 1'b0,
    PCS_MD_WAIT = 1'b1
  } pcs_state_e;

endpackage

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
// Module   : pc_sequencer
// Brief    : Decides PC load enable/value, F/D flush and pipeline stall,
//            including a bounded wait on multi-cycle multdiv operations.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH        = PC_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VECTOR = PC_RESET_VECTOR[WIDTH-1:0],
  parameter int unsigned INCR         = 1,
  parameter int unsigned MD_TIMEOUT   = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pc_cur,
  input  logic             stall_hazard,
  input  logic             md_start,
  input  logic             md_ready,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_target,
  output logic             pc_we,
  output logic [WIDTH-1:0] pc_next,
  output logic             flush_fd,
  output logic             stall_pipe,
  output logic             md_timeout
);

  localparam int unsigned     CNT_W    = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_TIMEOUT - 1);
  localparam logic [WIDTH-1:0] INCR_W   = WIDTH'(INCR);

  pcs_state_e       state_q, state_d;
  logic             pend_valid_q, pend_valid_d;
  logic [WIDTH-1:0] pend_target_q, pend_target_d;
  logic [CNT_W-1:0] md_cnt_q, md_cnt_d;

  logic [WIDTH-1:0] pc_incr;
  logic             md_last;
  logic             md_release;

  assign pc_incr    = pc_cur + INCR_W;
  assign md_last    = (md_cnt_q == CNT_LAST);
  assign md_release = md_ready || md_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= PCS_RUN;
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
      md_cnt_q      <= '0;
    end else begin
      state_q       <= state_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
      md_cnt_q      <= md_cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    md_cnt_d      = md_cnt_q;
    pc_we         = 1'b0;
    pc_next       = pc_incr;
    flush_fd      = 1'b0;
    stall_pipe    = 1'b0;
    md_timeout    = 1'b0;

    unique case (state_q)
      PCS_RUN: begin
        if (redirect_valid) begin
          pc_we    = 1'b1;
          pc_next  = redirect_target;
          flush_fd = 1'b1;
        end else if (md_start) begin
          stall_pipe = 1'b1;
          state_d    = PCS_MD_WAIT;
          md_cnt_d   = '0;
        end else if (stall_hazard) begin
          stall_pipe = 1'b1;
        end else begin
          pc_we = 1'b1;
        end
      end

      PCS_MD_WAIT: begin
        stall_pipe = 1'b1;
        md_cnt_d   = md_cnt_q + CNT_W'(1);
        if (md_release) begin
          stall_pipe   = 1'b0;
          pc_we        = 1'b1;
          md_timeout   = md_last;
          state_d      = PCS_RUN;
          pend_valid_d = 1'b0;
          if (redirect_valid) begin
            pc_next  = redirect_target;
            flush_fd = 1'b1;
          end else if (pend_valid_q) begin
            pc_next  = pend_target_q;
            flush_fd = 1'b1;
          end
        end else if (redirect_valid) begin
          // Newest redirect wins; it is replayed when multdiv releases.
          pend_valid_d  = 1'b1;
          pend_target_d = redirect_target;
        end
      end

      default: state_d = PCS_RUN;
    endcase

    if (reset) begin
      pc_we      = 1'b0;
      pc_next    = RESET_VECTOR;
      flush_fd   = 1'b0;
      stall_pipe = 1'b0;
      md_timeout = 1'b0;
    end
  end

endmodule

`default_nettype wire
